// File: rtl/midi_voice_allocator.sv
// MIDI voice allocator: parses a received MIDI byte stream (running status,
// channel filter, real-time bytes) and assigns note-on/note-off events to
// NUM_VOICES voice slots using retrigger / lowest-free / oldest-steal rules.
//   Latency  : completing data byte at edge N -> message strobe N+1 -> voice regs N+2.
//   Backpressure: none; the input strobes at most once every two cycles and the
//                 allocator retires one message per cycle.
// Ports: clk, rst_n (async active-low); rx_byte/rx_valid byte strobe in;
//        voice_note/voice_vel (7 bits per voice, voice i at [7i+6:7i]),
//        voice_gate, voice_trig (one-cycle), steal (one-cycle, with trig).
// Optional feature macro: SUSTAIN_PEDAL_EN (CC 64 sustain pedal handling).
module midi_voice_allocator #(
   parameter int NUM_VOICES = 4,
   parameter int CHANNEL    = 0
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic [7:0]              rx_byte,
   input  logic                    rx_valid,
   output logic [7*NUM_VOICES-1:0] voice_note,
   output logic [7*NUM_VOICES-1:0] voice_vel,
   output logic [NUM_VOICES-1:0]   voice_gate,
   output logic [NUM_VOICES-1:0]   voice_trig,
   output logic                    steal
);

   localparam logic [3:0] CH = CHANNEL[3:0];

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_D1   = 2'd1,
      ST_D2   = 2'd2
   } state_e;

   // ------------------------------------------------------------------
   // Stage 1: byte parser. Emits a raw 3-byte message at edge N.
   // ------------------------------------------------------------------
   state_e     state_q, state_d;
   logic [7:0] rs_q, rs_d;            // running status
   logic [6:0] d1_q, d1_d;
   logic       raw_vld_q, raw_vld_d;
   logic [7:0] raw_status_q, raw_status_d;
   logic [6:0] raw_d1_q, raw_d1_d;
   logic [6:0] raw_d2_q, raw_d2_d;

   always_comb begin
      state_d      = state_q;
      rs_d         = rs_q;
      d1_d         = d1_q;
      raw_vld_d    = 1'b0;
      raw_status_d = raw_status_q;
      raw_d1_d     = raw_d1_q;
      raw_d2_d     = raw_d2_q;
      if (rx_valid) begin
         if (rx_byte >= 8'hF8) begin
            // real-time byte: transparent to the parser
         end else if (rx_byte >= 8'hF0) begin
            rs_d    = 8'h00;
            state_d = ST_IDLE;
         end else if (rx_byte[7]) begin
            rs_d    = rx_byte;
            state_d = ST_D1;
         end else begin
            case (state_q)
               ST_IDLE: begin
                  // data with no running status is discarded
               end
               ST_D1: begin
                  // program change / channel pressure carry one data byte;
                  // they are complete here and of no interest downstream
                  if (rs_q[7:4] == 4'hC || rs_q[7:4] == 4'hD) begin
                     state_d = ST_D1;
                  end else begin
                     d1_d    = rx_byte[6:0];
                     state_d = ST_D2;
                  end
               end
               ST_D2: begin
                  raw_vld_d    = 1'b1;
                  raw_status_d = rs_q;
                  raw_d1_d     = d1_q;
                  raw_d2_d     = rx_byte[6:0];
                  state_d      = ST_D1;
               end
               default: state_d = ST_IDLE;
            endcase
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= ST_IDLE;
         rs_q         <= 8'h00;
         d1_q         <= 7'h00;
         raw_vld_q    <= 1'b0;
         raw_status_q <= 8'h00;
         raw_d1_q     <= 7'h00;
         raw_d2_q     <= 7'h00;
      end else begin
         state_q      <= state_d;
         rs_q         <= rs_d;
         d1_q         <= d1_d;
         raw_vld_q    <= raw_vld_d;
         raw_status_q <= raw_status_d;
         raw_d1_q     <= raw_d1_d;
         raw_d2_q     <= raw_d2_d;
      end
   end

   // ------------------------------------------------------------------
   // Stage 2: message classification, registered at N+1.
   // ------------------------------------------------------------------
   logic       msg_on_q, msg_on_d;
   logic       msg_off_q, msg_off_d;
   logic [6:0] msg_note_q, msg_note_d;
   logic [6:0] msg_vel_q, msg_vel_d;
   logic       ch_match;
`ifdef SUSTAIN_PEDAL_EN
   logic       msg_sus_set_q, msg_sus_set_d;
   logic       msg_sus_clr_q, msg_sus_clr_d;
`endif

   assign ch_match = (raw_status_q[3:0] == CH);

   always_comb begin
      msg_on_d   = 1'b0;
      msg_off_d  = 1'b0;
      msg_note_d = raw_d1_q;
      msg_vel_d  = raw_d2_q;
`ifdef SUSTAIN_PEDAL_EN
      msg_sus_set_d = 1'b0;
      msg_sus_clr_d = 1'b0;
`endif
      if (raw_vld_q && ch_match) begin
         if (raw_status_q[7:4] == 4'h9 && raw_d2_q != 7'h00) begin
            msg_on_d = 1'b1;
         end else if (raw_status_q[7:4] == 4'h8 || raw_status_q[7:4] == 4'h9) begin
            // 0x9n with velocity 0 is the running-status form of note-off
            msg_off_d = 1'b1;
         end
`ifdef SUSTAIN_PEDAL_EN
         else if (raw_status_q[7:4] == 4'hB && raw_d1_q == 7'd64) begin
            msg_sus_set_d = raw_d2_q[6];
            msg_sus_clr_d = ~raw_d2_q[6];
         end
`endif
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         msg_on_q   <= 1'b0;
         msg_off_q  <= 1'b0;
         msg_note_q <= 7'h00;
         msg_vel_q  <= 7'h00;
`ifdef SUSTAIN_PEDAL_EN
         msg_sus_set_q <= 1'b0;
         msg_sus_clr_q <= 1'b0;
`endif
      end else begin
         msg_on_q   <= msg_on_d;
         msg_off_q  <= msg_off_d;
         msg_note_q <= msg_note_d;
         msg_vel_q  <= msg_vel_d;
`ifdef SUSTAIN_PEDAL_EN
         msg_sus_set_q <= msg_sus_set_d;
         msg_sus_clr_q <= msg_sus_clr_d;
`endif
      end
   end

   // ------------------------------------------------------------------
   // Stage 3: voice bank, updated at N+2.
   // ------------------------------------------------------------------
   logic [6:0]            note_q [NUM_VOICES];
   logic [6:0]            note_d [NUM_VOICES];
   logic [6:0]            vel_q  [NUM_VOICES];
   logic [6:0]            vel_d  [NUM_VOICES];
   logic [3:0]            age_q  [NUM_VOICES];
   logic [3:0]            age_d  [NUM_VOICES];
   logic [NUM_VOICES-1:0] gate_q, gate_d;
   logic [NUM_VOICES-1:0] trig_q, trig_d;
   logic                  steal_q, steal_d;
`ifdef SUSTAIN_PEDAL_EN
   logic                  sustain_q, sustain_d;
   logic [NUM_VOICES-1:0] sus_mark_q, sus_mark_d;
`endif

   logic [NUM_VOICES-1:0] hit_oh, free_oh, old_oh, alloc_oh;
   logic                  hit_found, free_found;
   logic [3:0]            old_age;

   // Candidate selection for each allocation rule, all one-hot.
   always_comb begin
      hit_oh     = '0;
      free_oh    = '0;
      old_oh     = '0;
      hit_found  = 1'b0;
      free_found = 1'b0;
      old_oh[0]  = 1'b1;
      old_age    = age_q[0];
      for (int i = 0; i < NUM_VOICES; i++) begin
         if (!hit_found && gate_q[i] && note_q[i] == msg_note_q) begin
            hit_found = 1'b1;
            hit_oh[i] = 1'b1;
         end
         if (!free_found && !gate_q[i]) begin
            free_found = 1'b1;
            free_oh[i] = 1'b1;
         end
      end
      // strict '>' keeps the lowest index on ties
      for (int i = 1; i < NUM_VOICES; i++) begin
         if (age_q[i] > old_age) begin
            old_oh    = '0;
            old_oh[i] = 1'b1;
            old_age   = age_q[i];
         end
      end
   end

   always_comb begin
      note_d   = note_q;
      vel_d    = vel_q;
      age_d    = age_q;
      gate_d   = gate_q;
      trig_d   = '0;
      steal_d  = 1'b0;
      alloc_oh = '0;
`ifdef SUSTAIN_PEDAL_EN
      sustain_d  = sustain_q;
      sus_mark_d = sus_mark_q;
`endif
      if (msg_on_q) begin
         if (hit_found) begin
            alloc_oh = hit_oh;
         end else if (free_found) begin
            alloc_oh = free_oh;
         end else begin
            alloc_oh = old_oh;
            steal_d  = 1'b1;
         end
         for (int i = 0; i < NUM_VOICES; i++) begin
            if (alloc_oh[i]) begin
               note_d[i] = msg_note_q;
               vel_d[i]  = msg_vel_q;
               gate_d[i] = 1'b1;
               trig_d[i] = 1'b1;
               age_d[i]  = 4'd0;
`ifdef SUSTAIN_PEDAL_EN
               sus_mark_d[i] = 1'b0;
`endif
            end else if (age_q[i] != 4'hF) begin
               age_d[i] = age_q[i] + 4'd1;
            end
         end
      end else if (msg_off_q) begin
         for (int i = 0; i < NUM_VOICES; i++) begin
            if (gate_q[i] && note_q[i] == msg_note_q) begin
`ifdef SUSTAIN_PEDAL_EN
               if (sustain_q) begin
                  sus_mark_d[i] = 1'b1;
               end else begin
                  gate_d[i] = 1'b0;
               end
`else
               gate_d[i] = 1'b0;
`endif
            end
         end
      end
`ifdef SUSTAIN_PEDAL_EN
      else if (msg_sus_set_q) begin
         sustain_d = 1'b1;
      end else if (msg_sus_clr_q) begin
         sustain_d  = 1'b0;
         gate_d     = gate_q & ~sus_mark_q;
         sus_mark_d = '0;
      end
`endif
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NUM_VOICES; i++) begin
            note_q[i] <= 7'h00;
            vel_q[i]  <= 7'h00;
            age_q[i]  <= 4'd0;
         end
         gate_q  <= '0;
         trig_q  <= '0;
         steal_q <= 1'b0;
`ifdef SUSTAIN_PEDAL_EN
         sustain_q  <= 1'b0;
         sus_mark_q <= '0;
`endif
      end else begin
         note_q  <= note_d;
         vel_q   <= vel_d;
         age_q   <= age_d;
         gate_q  <= gate_d;
         trig_q  <= trig_d;
         steal_q <= steal_d;
`ifdef SUSTAIN_PEDAL_EN
         sustain_q  <= sustain_d;
         sus_mark_q <= sus_mark_d;
`endif
      end
   end

   // Pack per-voice registers onto the flat output buses.
   always_comb begin
      voice_note = '0;
      voice_vel  = '0;
      for (int i = 0; i < NUM_VOICES; i++) begin
         voice_note[7*i +: 7] = note_q[i];
         voice_vel[7*i +: 7]  = vel_q[i];
      end
   end

   assign voice_gate = gate_q;
   assign voice_trig = trig_q;
   assign steal      = steal_q;

endmodule

// File: tb/tb_midi_voice_allocator.sv
// Directed bench for midi_voice_allocator (NUM_VOICES=4, CHANNEL=0).
// Bytes are driven on the falling edge, one valid cycle then one idle cycle;
// outputs are sampled 1 time unit after the rising edge.
module tb_midi_voice_allocator;

   logic        clk;
   logic        rst_n;
   logic [7:0]  rx_byte;
   logic        rx_valid;
   logic [27:0] voice_note;
   logic [27:0] voice_vel;
   logic [3:0]  voice_gate;
   logic [3:0]  voice_trig;
   logic        steal;

   int checks = 0;
   int errors = 0;

   midi_voice_allocator #(.NUM_VOICES(4), .CHANNEL(0)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .rx_byte    (rx_byte),
      .rx_valid   (rx_valid),
      .voice_note (voice_note),
      .voice_vel  (voice_vel),
      .voice_gate (voice_gate),
      .voice_trig (voice_trig),
      .steal      (steal)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic send(input logic [7:0] b);
      @(negedge clk);
      rx_byte  = b;
      rx_valid = 1'b1;
      @(negedge clk);
      rx_valid = 1'b0;
   endtask

   // From the negedge after the accepting edge N, advance to just after N+2.
   task automatic wait_out();
      repeat (2) @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rx_valid = 1'b0;
      rx_byte  = 8'h00;
      rst_n    = 1'b0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic test_reset();
      do_reset();
      #1;
      checks++;
      if (voice_note !== 28'h0) begin errors++; $display("FAIL reset_note: got %h expected %h", voice_note, 28'h0); end
      checks++;
      if (voice_vel !== 28'h0) begin errors++; $display("FAIL reset_vel: got %h expected %h", voice_vel, 28'h0); end
      checks++;
      if ({voice_gate, voice_trig, steal} !== 9'h0) begin
         errors++; $display("FAIL reset_ctrl: gate %b trig %b steal %b expected all 0", voice_gate, voice_trig, steal);
      end
   endtask

   task automatic test_note_on();
      do_reset();
      send(8'h90); send(8'h3C); send(8'h64);
      @(posedge clk); #1;
      checks++;
      if (voice_trig !== 4'b0000) begin errors++; $display("FAIL note_on_early_trig: got %b expected 0000", voice_trig); end
      @(posedge clk); #1;
      checks++;
      if (voice_note !== 28'h000003C) begin errors++; $display("FAIL note_on_note: got %h expected %h", voice_note, 28'h000003C); end
      checks++;
      if (voice_vel !== 28'h0000064) begin errors++; $display("FAIL note_on_vel: got %h expected %h", voice_vel, 28'h0000064); end
      checks++;
      if (voice_gate !== 4'b0001 || voice_trig !== 4'b0001 || steal !== 1'b0) begin
         errors++; $display("FAIL note_on_ctrl: gate %b trig %b steal %b expected 0001 0001 0", voice_gate, voice_trig, steal);
      end
      @(posedge clk); #1;
      checks++;
      if (voice_trig !== 4'b0000) begin errors++; $display("FAIL note_on_trig_pulse: got %b expected 0000", voice_trig); end
   endtask

   task automatic test_running_status();
      do_reset();
      send(8'h90); send(8'h3C); send(8'h40);
      send(8'h40); send(8'h50);
      wait_out();
      checks++;
      if (voice_note !== 28'h000203C || voice_vel !== 28'h0002840) begin
         errors++; $display("FAIL running_on: note %h vel %h expected 000203C 0002840", voice_note, voice_vel);
      end
      checks++;
      if (voice_gate !== 4'b0011 || voice_trig !== 4'b0010) begin
         errors++; $display("FAIL running_on_ctrl: gate %b trig %b expected 0011 0010", voice_gate, voice_trig);
      end
      send(8'h3C); send(8'h00);
      wait_out();
      checks++;
      if (voice_gate !== 4'b0010 || voice_trig !== 4'b0000) begin
         errors++; $display("FAIL running_off: gate %b trig %b expected 0010 0000", voice_gate, voice_trig);
      end
      checks++;
      if (voice_note !== 28'h000203C || voice_vel !== 28'h0002840) begin
         errors++; $display("FAIL running_off_retain: note %h vel %h expected 000203C 0002840", voice_note, voice_vel);
      end
   endtask

   task automatic test_retrigger();
      do_reset();
      send(8'h90); send(8'h3C); send(8'h64);
      send(8'h3C); send(8'h20);
      wait_out();
      checks++;
      if (voice_vel !== 28'h0000020 || voice_gate !== 4'b0001 || voice_trig !== 4'b0001 || steal !== 1'b0) begin
         errors++; $display("FAIL retrigger: vel %h gate %b trig %b steal %b expected 0000020 0001 0001 0", voice_vel, voice_gate, voice_trig, steal);
      end
      // note-off with no matching voice leaves everything alone
      send(8'h80); send(8'h50); send(8'h00);
      wait_out();
      checks++;
      if (voice_gate !== 4'b0001 || voice_note !== 28'h000003C) begin
         errors++; $display("FAIL off_nomatch: gate %b note %h expected 0001 000003C", voice_gate, voice_note);
      end
      // 0x8n note-off with non-zero release velocity
      send(8'h80); send(8'h3C); send(8'h40);
      wait_out();
      checks++;
      if (voice_gate !== 4'b0000 || voice_trig !== 4'b0000) begin
         errors++; $display("FAIL off_8n: gate %b trig %b expected 0000 0000", voice_gate, voice_trig);
      end
   endtask

   task automatic test_steal();
      do_reset();
      send(8'h90);
      send(8'h3C); send(8'h64);
      send(8'h3E); send(8'h64);
      send(8'h40); send(8'h64);
      send(8'h41); send(8'h64);
      wait_out();
      checks++;
      if (voice_gate !== 4'b1111 || steal !== 1'b0) begin
         errors++; $display("FAIL fill: gate %b steal %b expected 1111 0", voice_gate, steal);
      end
      send(8'h43); send(8'h64);
      wait_out();
      checks++;
      if (voice_note !== {7'h41, 7'h40, 7'h3E, 7'h43} || voice_trig !== 4'b0001 || steal !== 1'b1) begin
         errors++; $display("FAIL steal_first: note %h trig %b steal %b expected %h 0001 1", voice_note, voice_trig, steal, {7'h41, 7'h40, 7'h3E, 7'h43});
      end
      @(posedge clk); #1;
      checks++;
      if (steal !== 1'b0) begin errors++; $display("FAIL steal_pulse: got %b expected 0", steal); end
      send(8'h45); send(8'h64);
      wait_out();
      checks++;
      if (voice_note !== {7'h41, 7'h40, 7'h45, 7'h43} || voice_trig !== 4'b0010 || steal !== 1'b1) begin
         errors++; $display("FAIL steal_second: note %h trig %b steal %b expected %h 0010 1", voice_note, voice_trig, steal, {7'h41, 7'h40, 7'h45, 7'h43});
      end
   endtask

   task automatic test_realtime();
      do_reset();
      send(8'h90); send(8'hF8); send(8'h3C); send(8'hF8); send(8'h64);
      wait_out();
      checks++;
      if (voice_note !== 28'h000003C || voice_vel !== 28'h0000064 || voice_gate !== 4'b0001 || voice_trig !== 4'b0001) begin
         errors++; $display("FAIL realtime: note %h vel %h gate %b trig %b expected 000003C 0000064 0001 0001", voice_note, voice_vel, voice_gate, voice_trig);
      end
      do_reset();
      send(8'h90); send(8'hF0); send(8'h3C); send(8'h64);
      wait_out();
      checks++;
      if (voice_note !== 28'h0 || voice_gate !== 4'b0000 || voice_trig !== 4'b0000) begin
         errors++; $display("FAIL sysex_a: note %h gate %b trig %b expected 0 0000 0000", voice_note, voice_gate, voice_trig);
      end
      send(8'h90); send(8'h3C); send(8'hF0); send(8'h64);
      wait_out();
      checks++;
      if (voice_note !== 28'h0 || voice_gate !== 4'b0000 || voice_trig !== 4'b0000) begin
         errors++; $display("FAIL sysex_b: note %h gate %b trig %b expected 0 0000 0000", voice_note, voice_gate, voice_trig);
      end
   endtask

   task automatic test_filter();
      do_reset();
      send(8'h3C); send(8'h64);           // data with no status after reset
      send(8'h91); send(8'h3C); send(8'h64);
      send(8'hC0); send(8'h3C); send(8'h64);   // program change: one data byte each
      wait_out();
      checks++;
      if (voice_note !== 28'h0 || voice_gate !== 4'b0000 || voice_trig !== 4'b0000) begin
         errors++; $display("FAIL filter: note %h gate %b trig %b expected 0 0000 0000", voice_note, voice_gate, voice_trig);
      end
      // sustain CC followed by note-on then note-off
      send(8'hB0); send(8'h40); send(8'h7F);
      send(8'h90); send(8'h3C); send(8'h64);
      send(8'h80); send(8'h3C); send(8'h00);
      wait_out();
      checks++;
`ifdef SUSTAIN_PEDAL_EN
      if (voice_gate !== 4'b0001) begin errors++; $display("FAIL cc_sustain: gate %b expected 0001", voice_gate); end
`else
      if (voice_gate !== 4'b0000) begin errors++; $display("FAIL cc_dropped: gate %b expected 0000", voice_gate); end
`endif
   endtask

   task automatic test_reset_mid();
      do_reset();
      send(8'h90); send(8'h3C); send(8'h64);
      send(8'h3E);
      rst_n = 1'b0;
      #1;
      checks++;
      if (voice_note !== 28'h0 || voice_vel !== 28'h0 || voice_gate !== 4'b0000 || voice_trig !== 4'b0000 || steal !== 1'b0) begin
         errors++; $display("FAIL reset_mid: note %h vel %h gate %b trig %b steal %b expected all 0", voice_note, voice_vel, voice_gate, voice_trig, steal);
      end
      @(negedge clk);
      rst_n = 1'b1;
      send(8'h64);
      wait_out();
      checks++;
      if (voice_note !== 28'h0 || voice_gate !== 4'b0000 || voice_trig !== 4'b0000) begin
         errors++; $display("FAIL reset_mid_tail: note %h gate %b trig %b expected 0 0000 0000", voice_note, voice_gate, voice_trig);
      end
   endtask

   initial begin
      rst_n    = 1'b0;
      rx_valid = 1'b0;
      rx_byte  = 8'h00;
      test_reset();
      test_note_on();
      test_running_status();
      test_retrigger();
      test_steal();
      test_realtime();
      test_filter();
      test_reset_mid();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
